mbinit_partner_responder: RTL and testbench

//  Parametrised MBINIT module-partner sideband responder; generalises the per-substate responders (REPAIRVAL, REPAIRMB).

---
 rtl/mbinit_pkg.sv | 36 +++
 rtl/mbinit_partner_responder_if.sv | 32 +++
 rtl/mbinit_timeout_counter.sv | 37 +++
 rtl/mbinit_partner_responder.sv | 170 +++++++++++++++++
 tb/tb_mbinit_partner_responder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: responder state encoding and default sideband message codes.
package mbinit_pkg;

    localparam int unsigned MSG_W_DEF = 4;

    localparam logic [3:0] REQ_INIT_DEF   = 4'h1;
    localparam logic [3:0] RSP_INIT_DEF   = 4'h2;
    localparam logic [3:0] REQ_RESULT_DEF = 4'h3;
    localparam logic [3:0] RSP_RESULT_DEF = 4'h4;
    localparam logic [3:0] REQ_DONE_DEF   = 4'h5;
    localparam logic [3:0] RSP_DONE_DEF   = 4'h6;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_INIT = 4'd1,
        ST_BUSY_INIT = 4'd2,
        ST_SEND_INIT = 4'd3,
        ST_WAIT_REQ  = 4'd4,
        ST_BUSY_RES  = 4'd5,
        ST_SEND_RES  = 4'd6,
        ST_BUSY_DONE = 4'd7,
        ST_SEND_DONE = 4'd8,
        ST_DONE      = 4'd9,
        ST_TIMEOUT   = 4'd10
    } mbinit_state_t;

    function automatic logic is_send(input mbinit_state_t st);
        return (st == ST_SEND_INIT) || (st == ST_SEND_RES) || (st == ST_SEND_DONE);
    endfunction

    // The watchdog only runs while an exchange is actually in flight.
    function automatic logic is_counting(input mbinit_state_t st);
        return (st != ST_IDLE) && (st != ST_DONE) && (st != ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/mbinit_partner_responder_if.sv
// Sideband request/response bundle between the MBINIT sequencer, the SB adaptors and the responder.
interface mbinit_partner_responder_if #(
    parameter int unsigned MSG_W = 4,
    parameter int unsigned RES_W = 1
);
    logic             i_enable;
    logic [MSG_W-1:0] i_Rx_SbMessage;
    logic             i_msg_valid;
    logic             i_Busy_SideBand;
    logic             i_falling_edge_busy;
    logic [RES_W-1:0] i_result;

    logic [MSG_W-1:0] o_TX_SbMessage;
    logic             o_ValidOutData;
    logic [RES_W-1:0] o_result;
    logic             o_end;
    logic             o_timeout;
    logic             o_enable_cons;

    modport slave (
        input  i_enable, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
               i_falling_edge_busy, i_result,
        output o_TX_SbMessage, o_ValidOutData, o_result, o_end, o_timeout, o_enable_cons
    );

    modport master (
        output i_enable, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
               i_falling_edge_busy, i_result,
        input  o_TX_SbMessage, o_ValidOutData, o_result, o_end, o_timeout, o_enable_cons
    );

endinterface

// File: rtl/mbinit_timeout_counter.sv
// Saturating per-request watchdog; expired flags the last counting cycle before timeout.
module mbinit_timeout_counter #(
    parameter int unsigned MAX = 800000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/mbinit_partner_responder.sv
// MBINIT partner-side sideband responder: init/result/done exchange with watchdog and sticky result.
//   state     | meaning
//   IDLE      | substate inactive, outputs cleared
//   WAIT_INIT | waiting for init request
//   BUSY_INIT | init response pending, TX busy
//   SEND_INIT | init response on TX
//   WAIT_REQ  | waiting for result or done request
//   BUSY_RES  | result response pending, TX busy
//   SEND_RES  | result response on TX
//   BUSY_DONE | done response pending, TX busy
//   SEND_DONE | done response on TX
//   DONE      | exchange complete
//   TIMEOUT   | watchdog expired
module mbinit_partner_responder
    import mbinit_pkg::*;
#(
    parameter int unsigned      MSG_W       = MSG_W_DEF,
    parameter int unsigned      RES_W       = 1,
    parameter logic [MSG_W-1:0] REQ_INIT    = MSG_W'(REQ_INIT_DEF),
    parameter logic [MSG_W-1:0] RSP_INIT    = MSG_W'(RSP_INIT_DEF),
    parameter logic [MSG_W-1:0] REQ_RESULT  = MSG_W'(REQ_RESULT_DEF),
    parameter logic [MSG_W-1:0] RSP_RESULT  = MSG_W'(RSP_RESULT_DEF),
    parameter logic [MSG_W-1:0] REQ_DONE    = MSG_W'(REQ_DONE_DEF),
    parameter logic [MSG_W-1:0] RSP_DONE    = MSG_W'(RSP_DONE_DEF),
    parameter int unsigned      TIMEOUT_CYC = 800000
) (
    input logic                      CLK,
    input logic                      rst_n,
    mbinit_partner_responder_if.slave sb
);

    mbinit_state_t state_q, state_d;
    logic [MSG_W-1:0] tx_msg_q, tx_msg_d;
    logic             valid_q;
    logic [RES_W-1:0] result_q;
    logic             end_q;
    logic             timeout_q;
    logic             enable_cons_q;

    logic restart;
    logic expired;
    logic wd_clear;
    logic wd_run;

    logic en;
    logic rx_init, rx_result, rx_done;
    logic busy, fall;

    assign en        = sb.i_enable;
    assign busy      = sb.i_Busy_SideBand;
    assign fall      = sb.i_falling_edge_busy;
    assign rx_init   = sb.i_msg_valid && (sb.i_Rx_SbMessage == REQ_INIT);
    assign rx_result = sb.i_msg_valid && (sb.i_Rx_SbMessage == REQ_RESULT);
    assign rx_done   = sb.i_msg_valid && (sb.i_Rx_SbMessage == REQ_DONE);

    assign wd_run   = is_counting(state_q);
    assign wd_clear = !en || (state_q == ST_IDLE) || restart;

    mbinit_timeout_counter #(
        .MAX(TIMEOUT_CYC)
    ) u_wdog (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clear_i  (wd_clear),
        .run_i    (wd_run),
        .expired_o(expired)
    );

    // Precedence: enable drop, then accepted request (restart), then expiry, then normal progress.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_INIT;
                ST_WAIT_INIT: begin
                    if (rx_init) begin
                        state_d = ST_BUSY_INIT;
                        restart = 1'b1;
                    end else if (expired) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_BUSY_INIT: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (!busy) state_d = ST_SEND_INIT;
                end
                ST_SEND_INIT: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (fall)  state_d = ST_WAIT_REQ;
                end
                ST_WAIT_REQ: begin
                    if (rx_result) begin
                        state_d = ST_BUSY_RES;
                        restart = 1'b1;
                    end else if (rx_done) begin
                        state_d = ST_BUSY_DONE;
                        restart = 1'b1;
                    end else if (expired) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_BUSY_RES: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (!busy) state_d = ST_SEND_RES;
                end
                ST_SEND_RES: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (fall)  state_d = ST_WAIT_REQ;
                end
                ST_BUSY_DONE: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (!busy) state_d = ST_SEND_DONE;
                end
                ST_SEND_DONE: begin
                    if (expired)    state_d = ST_TIMEOUT;
                    else if (fall)  state_d = ST_DONE;
                end
                ST_DONE:      state_d = ST_DONE;
                ST_TIMEOUT:   state_d = ST_TIMEOUT;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_msg_d = '0;
        case (state_d)
            ST_SEND_INIT: tx_msg_d = RSP_INIT;
            ST_SEND_RES:  tx_msg_d = RSP_RESULT;
            ST_SEND_DONE: tx_msg_d = RSP_DONE;
            default:      tx_msg_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tx_msg_q      <= '0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            end_q         <= 1'b0;
            timeout_q     <= 1'b0;
            enable_cons_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_msg_q      <= tx_msg_d;
            valid_q       <= is_send(state_d);
            end_q         <= (state_d == ST_DONE);
            timeout_q     <= (state_d == ST_TIMEOUT);
            enable_cons_q <= 1'b1;
            // Result is captured once per result response and survives until the substate ends.
            if (state_d == ST_IDLE) begin
                result_q <= '0;
            end else if ((state_q == ST_BUSY_RES) && (state_d == ST_SEND_RES)) begin
                result_q <= sb.i_result;
            end
        end
    end

    assign sb.o_TX_SbMessage = tx_msg_q;
    assign sb.o_ValidOutData = valid_q;
    assign sb.o_result       = result_q;
    assign sb.o_end          = end_q;
    assign sb.o_timeout      = timeout_q;
    assign sb.o_enable_cons  = enable_cons_q;

endmodule

// File: tb/tb_mbinit_partner_responder.sv
// Scenario bench for the MBINIT partner responder with a response scoreboard.
module tb_mbinit_partner_responder;
    import mbinit_pkg::*;

    localparam int MSG_W = 4;
    localparam int RES_W = 16;
    localparam int TO    = 16;

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic [RES_W-1:0] res;
        bit               chk_res;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    mbinit_partner_responder_if #(.MSG_W(MSG_W), .RES_W(RES_W)) sb_if ();

    mbinit_partner_responder #(
        .MSG_W(MSG_W),
        .RES_W(RES_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .sb   (sb_if)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_req(input logic [MSG_W-1:0] code);
        sb_if.i_msg_valid    = 1'b1;
        sb_if.i_Rx_SbMessage = code;
        tick();
        sb_if.i_msg_valid    = 1'b0;
        sb_if.i_Rx_SbMessage = '0;
    endtask

    task automatic pulse_fall();
        sb_if.i_falling_edge_busy = 1'b1;
        tick();
        sb_if.i_falling_edge_busy = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output int waited);
        waited = 0;
        while (!sb_if.o_ValidOutData && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    // Brings the responder from IDLE through the init exchange into WAIT_REQ.
    task automatic enter_wait_req();
        sb_if.i_enable = 1'b0;
        tick();
        sb_if.i_enable = 1'b1;
        sb_if.i_Busy_SideBand = 1'b0;
        tick();
        send_req(4'h1);
        tick();
        pulse_fall();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b0 || sb_if.o_TX_SbMessage !== 4'h0) begin
            n_err++;
            $display("FAIL reset_tx: got valid=%b msg=%h want 0/0", sb_if.o_ValidOutData, sb_if.o_TX_SbMessage);
        end
        n_cmp++;
        if (sb_if.o_result !== 16'h0 || sb_if.o_end !== 1'b0 || sb_if.o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: got res=%h end=%b to=%b want 0", sb_if.o_result, sb_if.o_end, sb_if.o_timeout);
        end
        n_cmp++;
        if (sb_if.o_enable_cons !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got cons=%b state=%0d want 0/IDLE", sb_if.o_enable_cons, dut.state_q);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (sb_if.o_enable_cons !== 1'b1) begin
            n_err++;
            $display("FAIL enable_cons: got %b want 1", sb_if.o_enable_cons);
        end
    endtask

    task automatic test_init();
        int   waited;
        exp_t e;
        sb_if.i_enable = 1'b1;
        tick();
        n_cmp++;
        if (dut.state_q !== ST_WAIT_INIT) begin
            n_err++;
            $display("FAIL init_enter: got state %0d want %0d", dut.state_q, ST_WAIT_INIT);
        end
        exp_q.push_back('{msg: 4'h2, res: '0, chk_res: 1'b0});
        send_req(4'h1);
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b0) begin
            n_err++;
            $display("FAIL init_busy_valid: got %b want 0", sb_if.o_ValidOutData);
        end
        wait_tx(4, waited);
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || waited !== 1) begin
            n_err++;
            $display("FAIL init_latency: got valid=%b after %0d cycles want 1 after 1", sb_if.o_ValidOutData, waited);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_TX_SbMessage !== e.msg) begin
            n_err++;
            $display("FAIL init_rsp: got %h want %h", sb_if.o_TX_SbMessage, e.msg);
        end
        pulse_fall();
        n_cmp++;
        if (dut.state_q !== ST_WAIT_REQ || sb_if.o_ValidOutData !== 1'b0) begin
            n_err++;
            $display("FAIL init_to_wait_req: got state=%0d valid=%b want %0d/0", dut.state_q, sb_if.o_ValidOutData, ST_WAIT_REQ);
        end
    endtask

    task automatic test_result_done();
        int   waited;
        exp_t e;
        sb_if.i_result = 16'hA5F0;
        exp_q.push_back('{msg: 4'h4, res: 16'hA5F0, chk_res: 1'b1});
        send_req(4'h3);
        wait_tx(4, waited);
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || sb_if.o_TX_SbMessage !== e.msg || sb_if.o_result !== e.res) begin
            n_err++;
            $display("FAIL result_rsp: got valid=%b msg=%h res=%h want 1/%h/%h", sb_if.o_ValidOutData, sb_if.o_TX_SbMessage, sb_if.o_result, e.msg, e.res);
        end
        sb_if.i_result = 16'h0000;
        pulse_fall();
        exp_q.push_back('{msg: 4'h6, res: 16'hA5F0, chk_res: 1'b1});
        send_req(4'h5);
        wait_tx(4, waited);
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || sb_if.o_TX_SbMessage !== e.msg || sb_if.o_result !== e.res) begin
            n_err++;
            $display("FAIL done_rsp: got valid=%b msg=%h res=%h want 1/%h/%h", sb_if.o_ValidOutData, sb_if.o_TX_SbMessage, sb_if.o_result, e.msg, e.res);
        end
        n_cmp++;
        if (sb_if.o_end !== 1'b0) begin
            n_err++;
            $display("FAIL end_early: got %b want 0", sb_if.o_end);
        end
        pulse_fall();
        n_cmp++;
        if (sb_if.o_end !== 1'b1 || sb_if.o_ValidOutData !== 1'b0) begin
            n_err++;
            $display("FAIL end_set: got end=%b valid=%b want 1/0", sb_if.o_end, sb_if.o_ValidOutData);
        end
        repeat (TO + 4) tick();
        n_cmp++;
        if (sb_if.o_end !== 1'b1 || sb_if.o_timeout !== 1'b0 || sb_if.o_result !== 16'hA5F0) begin
            n_err++;
            $display("FAIL done_hold: got end=%b to=%b res=%h want 1/0/a5f0", sb_if.o_end, sb_if.o_timeout, sb_if.o_result);
        end
    endtask

    task automatic test_busy_hold();
        int   waited;
        int   early;
        exp_t e;
        enter_wait_req();
        pulse_fall();
        n_cmp++;
        if (dut.state_q !== ST_WAIT_REQ) begin
            n_err++;
            $display("FAIL stray_fall: got state %0d want %0d", dut.state_q, ST_WAIT_REQ);
        end
        sb_if.i_Busy_SideBand = 1'b1;
        sb_if.i_result = 16'h1234;
        exp_q.push_back('{msg: 4'h4, res: 16'h1234, chk_res: 1'b1});
        send_req(4'h3);
        early = 0;
        for (int i = 0; i < 4; i++) begin
            if (sb_if.o_ValidOutData !== 1'b0) early++;
            tick();
        end
        if (sb_if.o_ValidOutData !== 1'b0) early++;
        n_cmp++;
        if (early != 0) begin
            n_err++;
            $display("FAIL busy_suppress: got %0d valid cycles while busy want 0", early);
        end
        sb_if.i_Busy_SideBand = 1'b0;
        wait_tx(4, waited);
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || waited !== 1 || sb_if.o_TX_SbMessage !== e.msg || sb_if.o_result !== e.res) begin
            n_err++;
            $display("FAIL busy_release: got valid=%b wait=%0d msg=%h res=%h want 1/1/%h/%h", sb_if.o_ValidOutData, waited, sb_if.o_TX_SbMessage, sb_if.o_result, e.msg, e.res);
        end
        pulse_fall();
    endtask

    task automatic test_back_to_back();
        int   waited;
        exp_t e;
        logic [15:0] vals [2];
        vals[0] = 16'h0001;
        vals[1] = 16'h8000;
        for (int k = 0; k < 2; k++) begin
            sb_if.i_result = vals[k];
            exp_q.push_back('{msg: 4'h4, res: vals[k], chk_res: 1'b1});
            send_req(4'h3);
            wait_tx(4, waited);
            e = exp_q.pop_front();
            n_cmp++;
            if (sb_if.o_ValidOutData !== 1'b1 || sb_if.o_TX_SbMessage !== e.msg || sb_if.o_result !== e.res) begin
                n_err++;
                $display("FAIL b2b_result%0d: got valid=%b msg=%h res=%h want 1/%h/%h", k, sb_if.o_ValidOutData, sb_if.o_TX_SbMessage, sb_if.o_result, e.msg, e.res);
            end
            pulse_fall();
        end
    endtask

    task automatic test_timeout();
        int early;
        sb_if.i_enable = 1'b0;
        tick();
        sb_if.i_enable = 1'b1;
        tick();
        early = 0;
        for (int i = 1; i <= TO - 1; i++) begin
            tick();
            if (sb_if.o_timeout !== 1'b0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_err++;
            $display("FAIL timeout_early: got %0d early cycles want 0", early);
        end
        tick();
        n_cmp++;
        if (sb_if.o_timeout !== 1'b1 || dut.state_q !== ST_TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_fire: got to=%b state=%0d want 1/%0d", sb_if.o_timeout, dut.state_q, ST_TIMEOUT);
        end
        send_req(4'h1);
        tick();
        n_cmp++;
        if (sb_if.o_timeout !== 1'b1 || sb_if.o_ValidOutData !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky: got to=%b valid=%b want 1/0", sb_if.o_timeout, sb_if.o_ValidOutData);
        end
        sb_if.i_enable = 1'b0;
        tick();
        n_cmp++;
        if (sb_if.o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: got %b want 0", sb_if.o_timeout);
        end
        sb_if.i_enable = 1'b1;
        sb_if.i_Busy_SideBand = 1'b1;
        tick();
        repeat (TO - 1) tick();
        send_req(4'h1);
        n_cmp++;
        if (sb_if.o_timeout !== 1'b0 || dut.state_q !== ST_BUSY_INIT) begin
            n_err++;
            $display("FAIL timeout_restart: got to=%b state=%0d want 0/%0d", sb_if.o_timeout, dut.state_q, ST_BUSY_INIT);
        end
        sb_if.i_Busy_SideBand = 1'b0;
    endtask

    task automatic test_abort();
        int   waited;
        exp_t e;
        enter_wait_req();
        sb_if.i_result = 16'hBEEF;
        exp_q.push_back('{msg: 4'h4, res: 16'hBEEF, chk_res: 1'b1});
        send_req(4'h3);
        wait_tx(4, waited);
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || sb_if.o_result !== e.res) begin
            n_err++;
            $display("FAIL abort_pre: got valid=%b res=%h want 1/%h", sb_if.o_ValidOutData, sb_if.o_result, e.res);
        end
        sb_if.i_enable = 1'b0;
        tick();
        n_cmp++;
        if (dut.state_q !== ST_IDLE || sb_if.o_ValidOutData !== 1'b0 || sb_if.o_TX_SbMessage !== 4'h0
            || sb_if.o_result !== 16'h0 || sb_if.o_end !== 1'b0 || sb_if.o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got state=%0d valid=%b msg=%h res=%h want IDLE and zeros", dut.state_q, sb_if.o_ValidOutData, sb_if.o_TX_SbMessage, sb_if.o_result);
        end
        enter_wait_req();
        exp_q.push_back('{msg: 4'h4, res: 16'hBEEF, chk_res: 1'b1});
        send_req(4'h3);
        wait_tx(4, waited);
        e = exp_q.pop_front();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b1 || sb_if.o_TX_SbMessage !== e.msg) begin
            n_err++;
            $display("FAIL rst_pre: got valid=%b msg=%h want 1/%h", sb_if.o_ValidOutData, sb_if.o_TX_SbMessage, e.msg);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (sb_if.o_ValidOutData !== 1'b0 || sb_if.o_result !== 16'h0 || sb_if.o_enable_cons !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_err++;
            $display("FAIL rst_mid: got valid=%b res=%h cons=%b state=%0d want zeros/IDLE", sb_if.o_ValidOutData, sb_if.o_result, sb_if.o_enable_cons, dut.state_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ignore();
        int stray;
        sb_if.i_enable = 1'b0;
        tick();
        sb_if.i_enable = 1'b1;
        tick();
        stray = 0;
        send_req(4'h5);
        if (sb_if.o_ValidOutData !== 1'b0) stray++;
        send_req(4'h3);
        if (sb_if.o_ValidOutData !== 1'b0) stray++;
        sb_if.i_Rx_SbMessage = 4'h1;
        tick();
        sb_if.i_Rx_SbMessage = 4'h0;
        tick();
        if (sb_if.o_ValidOutData !== 1'b0) stray++;
        n_cmp++;
        if (stray != 0 || dut.state_q !== ST_WAIT_INIT) begin
            n_err++;
            $display("FAIL ignore_mismatch: got %0d tx cycles state=%0d want 0/%0d", stray, dut.state_q, ST_WAIT_INIT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish want finish");
        $fatal(1, "time limit");
    end

    initial begin
        sb_if.i_enable            = 1'b0;
        sb_if.i_Rx_SbMessage      = '0;
        sb_if.i_msg_valid         = 1'b0;
        sb_if.i_Busy_SideBand     = 1'b0;
        sb_if.i_falling_edge_busy = 1'b0;
        sb_if.i_result            = '0;
        test_reset();
        test_init();
        test_result_done();
        test_busy_hold();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_ignore();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
